inst_mem_resp: RTL and testbench
================================

Name: inst_mem_resp

Overview:
Instruction-memory responder serving the fetch stage's PC-driven instruction requests.
- Accepts one word-aligned fetch address per valid/ready handshake.
- Models a configurable number of access wait states.
- Returns the 32-bit instruction on a valid/ready response channel.
- A side write port preloads program words for simulation and boot.

Parameters:
ADDR_WIDTH, 32, width of fetch and write addresses (byte addresses).
DATA_WIDTH, 32, instruction word width.
DEPTH_WORDS, 1024, memory depth in words; power of two.
WAIT_CYCLES, 1, extra access cycles before the response is presented; legal range 0..15.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high.
req_valid  input  1  fetch request valid.
req_ready  output  1  responder can accept a request this cycle.
req_addr  input  ADDR_WIDTH  fetch byte address.
resp_valid  output  1  resp_inst/resp_err valid.
resp_ready  input  1  fetch side consumes the response.
resp_inst  output  DATA_WIDTH  instruction word.
resp_err  output  1  misaligned or out-of-range fetch (see Optional Feature).
wr_en  input  1  preload write strobe.
wr_addr  input  ADDR_WIDTH  preload byte address; bits [1:0] ignored.
wr_data  input  DATA_WIDTH  preload word.

Behaviour:
- Reset state (reset high at clk edge): state=IDLE, resp_valid=0, resp_inst=0, resp_err=0, wait counter=0, captured address=0. Memory array is not cleared.
- Reset mid-operation discards any pending or presented response. No response is emitted for a request accepted before reset.
- Request handshake:
  - A request is accepted when req_valid && req_ready at a rising edge; req_addr is captured on that edge.
  - req_ready = 1 in IDLE.
  - req_ready = resp_ready in RESP, giving back-to-back accept in the same cycle the response is consumed.
  - req_ready = 0 in WAIT.
- State machine (IDLE, WAIT, RESP):
  - IDLE, request accepted: if WAIT_CYCLES==0, go to RESP; else load counter=WAIT_CYCLES-1 and go to WAIT.
  - WAIT: counter decrements each cycle; when counter==0, go to RESP.
  - RESP: resp_valid=1; resp_inst and resp_err are held stable until resp_ready=1.
    - On consume with a new request accepted: behave exactly as the IDLE accept transition.
    - On consume without a new request: go to IDLE, resp_valid=0.
- Latency: resp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge. Sustained throughput is one word per WAIT_CYCLES+1 cycles when resp_ready is held high.
- Read data:
  - Word index = captured_addr[log2(DEPTH_WORDS)+1:2].
  - The array is read on the edge that enters RESP, and resp_inst is registered on that edge.
- Preload write:
  - When wr_en=1, the word at wr_addr[log2(DEPTH_WORDS)+1:2] is written at the edge. Writes are allowed in any state.
  - A write to the word being read on the same RESP-entry edge returns the old data (read-before-write).
  - A write never alters a response already presented.
- Arithmetic: counter is 4 bits. Address bits above the index are ignored unless IMEM_ERR_EN is defined.

Optional Feature:
Macro IMEM_ERR_EN.
- Defined: a request with addr[1:0]!=0, or with addr >= DEPTH_WORDS*4, responds with resp_err=1 and resp_inst=32'h00000013 (NOP). Latency and handshake are unchanged, and the memory is not read.
- Not defined: resp_err is tied to 0, addr[1:0] are ignored, and upper address bits wrap modulo DEPTH_WORDS.

Test Plan:
1. WAIT_CYCLES=1: preload word 3 = 32'h00A00093; request addr 0x0C, resp_ready=1 → resp_valid exactly 2 cycles after accept with resp_inst=32'h00A00093, resp_err=0.
2. Back-to-back: requests 0x00, 0x04, 0x08 with resp_ready=1 and req_valid held → three responses in order, one every 2 cycles, req_ready high on each consume cycle.
3. Backpressure: hold resp_ready=0 for 5 cycles after resp_valid → resp_inst stable, req_ready=0; release → consumed, then IDLE.
4. WAIT_CYCLES=0: request 0x10 → resp_valid next cycle. A wr_en to word 4 on the same edge as the RESP-entry read returns the old value; a re-fetch returns the new value.
5. IMEM_ERR_EN, DEPTH_WORDS=1024: request 0x0000_1000 → resp_err=1, resp_inst=32'h00000013. Request 0x02 → resp_err=1. Without the macro, 0x1000 returns word 0.
6. Assert reset during WAIT → next cycle state IDLE, resp_valid=0, req_ready=1, and no stale response appears.

Source files
------------

// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: one fetch per handshake, WAIT_CYCLES access delay, preload write port.
// Optional IMEM_ERR_EN: misaligned/out-of-range fetches answer with resp_err=1 and a NOP.
module inst_mem_resp #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_inst,
  output logic                  resp_err,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] resp_inst_q;
  logic                  resp_err_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                  accept;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_err;
  logic [DATA_WIDTH-1:0] rd_word;

  assign req_ready  = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_inst  = resp_inst_q;
  assign resp_err   = resp_err_q;

  // RESP is entered either from WAIT (captured address) or straight from an accept when WAIT_CYCLES==0.
  assign rd_addr = (state_q == WAIT) ? addr_q : req_addr;

`ifdef IMEM_ERR_EN
  assign rd_err = (rd_addr[1:0] != 2'b00) || (rd_addr >= ADDR_WIDTH'(DEPTH_WORDS * 4));
`else
  assign rd_err = 1'b0;
  logic unused_rd_bits;
  assign unused_rd_bits = ^{rd_addr[1:0], rd_addr[ADDR_WIDTH-1:IDX_W+2]};
`endif

  assign rd_word = rd_err ? NOP_INST : mem[rd_addr[IDX_W+1:2]];

  logic unused_wr_bits;
  assign unused_wr_bits = ^{wr_addr[1:0], wr_addr[ADDR_WIDTH-1:IDX_W+2]};

  // Non-blocking write keeps a same-edge read returning the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[IDX_W+1:2]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      resp_inst_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= RESP;
            resp_inst_q <= rd_word;
            resp_err_q  <= rd_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready && !accept) state_q <= IDLE;
        end
        default: ;
      endcase
      // Accept is legal in IDLE and on the consume cycle of RESP; both take the same path.
      if (accept) begin
        addr_q <= req_addr;
        if (WAIT_CYCLES == 0) begin
          state_q     <= RESP;
          resp_inst_q <= rd_word;
          resp_err_q  <= rd_err;
        end else begin
          state_q <= WAIT;
          cnt_q   <= 4'(WAIT_CYCLES - 1);
        end
      end
    end
  end
endmodule

// File: tb/tb_inst_mem_resp.sv
// Directed bench for inst_mem_resp: WAIT_CYCLES=1 and WAIT_CYCLES=0 instances, vector table plus corner sequences.
module tb_inst_mem_resp;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid1 = 0, req_ready1, resp_valid1, resp_ready1 = 0, resp_err1, wr_en1 = 0;
  logic [31:0] req_addr1 = 0, resp_inst1, wr_addr1 = 0, wr_data1 = 0;
  logic        req_valid0 = 0, req_ready0, resp_valid0, resp_ready0 = 0, resp_err0, wr_en0 = 0;
  logic [31:0] req_addr0 = 0, resp_inst0, wr_addr0 = 0, wr_data0 = 0;

  inst_mem_resp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_inst(resp_inst1), .resp_err(resp_err1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1));

  inst_mem_resp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_inst(resp_inst0), .resp_err(resp_err0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write1(input logic [31:0] a, input logic [31:0] d);
    wr_en1 = 1; wr_addr1 = a; wr_data1 = d;
    @(posedge clk); #1 wr_en1 = 0;
  endtask

  // Single fetch on the WAIT_CYCLES=1 instance; lat counts cycles from accept edge to resp_valid.
  task automatic fetch1(input logic [31:0] a, output logic [31:0] inst, output logic err, output int lat);
    req_addr1 = a; req_valid1 = 1; resp_ready1 = 1;
    @(posedge clk); #1 req_valid1 = 0;
    lat = 1;
    while (!resp_valid1 && lat < 20) begin
      @(posedge clk); #1 lat++;
    end
    inst = resp_inst1; err = resp_err1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic [31:0] inst, hold;
    logic        err;
    int          lat;
    bit          seen;

    vt[0] = '{32'h0000_000C, 32'h00A0_0093, 1'b0};
    vt[1] = '{32'h0000_0000, 32'h1000_0000, 1'b0};
    vt[2] = '{32'h0000_0004, 32'h1000_0001, 1'b0};
    vt[3] = '{32'h0000_001C, 32'h1000_0007, 1'b0};
    vt[4] = '{32'h0000_0FFC, 32'hDEAD_BEEF, 1'b0};
`ifdef IMEM_ERR_EN
    vt[5] = '{32'h0000_1000, 32'h0000_0013, 1'b1};
    vt[6] = '{32'h0000_000E, 32'h0000_0013, 1'b1};
    vt[7] = '{32'h0000_1004, 32'h0000_0013, 1'b1};
    vt[8] = '{32'h0000_0002, 32'h0000_0013, 1'b1};
`else
    vt[5] = '{32'h0000_1000, 32'h1000_0000, 1'b0};
    vt[6] = '{32'h0000_000E, 32'h00A0_0093, 1'b0};
    vt[7] = '{32'h0000_1004, 32'h1000_0001, 1'b0};
    vt[8] = '{32'h0000_0002, 32'h1000_0000, 1'b0};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid1}, 32'd0);
    chk("rst_resp_inst", resp_inst1, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err1}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready1}, 32'd1);

    // Preload (writes also land while the bench idles in IDLE)
    for (int i = 0; i < 8; i++) write1(i * 4, (i == 3) ? 32'h00A0_0093 : 32'h1000_0000 + i);
    write1(32'h0000_0FFC, 32'hDEAD_BEEF);

    // Table-driven fetches
    for (int i = 0; i < 9; i++) begin
      fetch1(vt[i].addr, inst, err, lat);
      chk($sformatf("vec%0d_inst", i), inst, vt[i].inst);
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vt[i].err});
      chk($sformatf("vec%0d_latency", i), lat, 32'd2);
    end
    chk("after_consume_idle", {31'b0, resp_valid1}, 32'd0);

    // Back-to-back: req_valid held, resp_ready high, one response every 2 cycles
    resp_ready1 = 1; req_valid1 = 1; req_addr1 = 32'h0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) req_addr1 = (i + 1) * 4; else req_valid1 = 0;
      chk($sformatf("b2b%0d_wait_no_valid", i), {31'b0, resp_valid1}, 32'd0);
      @(posedge clk); @(negedge clk);
      chk($sformatf("b2b%0d_valid", i), {31'b0, resp_valid1}, 32'd1);
      chk($sformatf("b2b%0d_inst", i), resp_inst1, 32'h1000_0000 + i);
      chk($sformatf("b2b%0d_req_ready", i), {31'b0, req_ready1}, (i < 2) ? 32'd1 : 32'd1);
      @(posedge clk); #1;
    end
    chk("b2b_end_idle", {31'b0, resp_valid1}, 32'd0);

    // Backpressure: response held for 5 cycles, write to that word must not disturb it
    resp_ready1 = 0; req_addr1 = 32'h0000_000C; req_valid1 = 1;
    @(posedge clk); #1 req_valid1 = 0;
    @(posedge clk); #1;
    chk("bp_valid", {31'b0, resp_valid1}, 32'd1);
    hold = resp_inst1;
    chk("bp_inst", hold, 32'h00A0_0093);
    req_valid1 = 1; req_addr1 = 32'h0;
    wr_en1 = 1; wr_addr1 = 32'h0000_000C; wr_data1 = 32'h5555_AAAA;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_stable%0d", c), resp_inst1, 32'h00A0_0093);
      chk($sformatf("bp_req_ready%0d", c), {31'b0, req_ready1}, 32'd0);
      @(posedge clk); #1 wr_en1 = 0;
    end
    req_valid1 = 0; resp_ready1 = 1;
    @(posedge clk); #1;
    chk("bp_released_idle", {31'b0, resp_valid1}, 32'd0);
    chk("bp_released_ready", {31'b0, req_ready1}, 32'd1);

    // WAIT_CYCLES=0: same-edge write returns old word, re-fetch sees new word
    wr_en0 = 1; wr_addr0 = 32'h10; wr_data0 = 32'h1111_1111;
    @(posedge clk); #1;
    wr_data0 = 32'h2222_2222; req_valid0 = 1; req_addr0 = 32'h10; resp_ready0 = 1;
    @(posedge clk); #1 wr_en0 = 0; req_valid0 = 0;
    chk("w0_valid_next_cycle", {31'b0, resp_valid0}, 32'd1);
    chk("w0_read_before_write", resp_inst0, 32'h1111_1111);
    @(posedge clk); #1;
    chk("w0_consumed", {31'b0, resp_valid0}, 32'd0);
    req_valid0 = 1;
    @(posedge clk); #1 req_valid0 = 0;
    chk("w0_refetch_valid", {31'b0, resp_valid0}, 32'd1);
    chk("w0_refetch_new", resp_inst0, 32'h2222_2222);
    @(posedge clk); #1;

    // Reset during WAIT discards the pending fetch
    req_valid1 = 1; req_addr1 = 32'h0000_0004; resp_ready1 = 1;
    @(posedge clk); #1 req_valid1 = 0; reset = 1;
    chk("rstw_in_wait", {31'b0, req_ready1}, 32'd0);
    @(posedge clk); #1 reset = 0;
    chk("rstw_valid", {31'b0, resp_valid1}, 32'd0);
    chk("rstw_req_ready", {31'b0, req_ready1}, 32'd1);
    chk("rstw_inst", resp_inst1, 32'd0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (resp_valid1) seen = 1;
    end
    chk("rstw_no_stale", {31'b0, seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
